ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Three-requester round-robin arbiter for a single-ported cell RAM.
// Requester 0 = cell engine, 1 = brush draw, 2 = VRAM copy. An owner keeps
// the RAM for at most MAX_BURST consecutive cycles while others wait, then a
// one-cycle HANDOVER gap separates owners.

// Per-requester gating: passes this requester's RAM strobes only while it
// holds the grant, so the top can simply OR all lanes together.
module ram_port_arbiter_lane #(
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 2
) (
   input  logic                  gnt,
   input  logic                  rd_en,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_vld_nxt,
   output logic                  wr_en_m,
   output logic [ADDR_WIDTH-1:0] rd_addr_m,
   output logic [ADDR_WIDTH-1:0] wr_addr_m,
   output logic [DATA_WIDTH-1:0] wr_data_m
);

   // mask every strobe and bus with the grant
   always_comb begin
      rd_vld_nxt = gnt & rd_en;
      wr_en_m    = gnt & wr_en;
      rd_addr_m  = rd_addr & {ADDR_WIDTH{gnt}};
      wr_addr_m  = wr_addr & {ADDR_WIDTH{gnt}};
      wr_data_m  = wr_data & {DATA_WIDTH{gnt}};
   end

endmodule

module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 2,
   parameter int MAX_BURST  = 16
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   input  logic [2:0]              req_i,
   input  logic [2:0]              rd_en_i,
   input  logic [2:0]              wr_en_i,
   input  logic [3*ADDR_WIDTH-1:0] rd_addr_i,
   input  logic [3*ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [3*DATA_WIDTH-1:0] wr_data_i,
   input  logic [DATA_WIDTH-1:0]   ram_rd_data_i,
   output logic [2:0]              gnt_o,
   output logic [2:0]              rd_valid_o,
   output logic [DATA_WIDTH-1:0]   rd_data_o,
   output logic [ADDR_WIDTH-1:0]   ram_rd_address_o,
   output logic [ADDR_WIDTH-1:0]   ram_wr_address_o,
   output logic [DATA_WIDTH-1:0]   ram_wr_data_o,
   output logic                    ram_wr_en_o,
   output logic                    busy_o
);

   localparam int NUM_REQ = 3;
   // a one-cycle burst would leave a zero-width counter; keep at least 1 bit
   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

   typedef enum logic [1:0] {IDLE, GRANT, HANDOVER} state_t;

   state_t        state, state_nxt;
   logic [1:0]    owner, owner_nxt;
   logic [1:0]    last_owner, last_owner_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    gnt_q, gnt_nxt;
   logic [2:0]    rd_valid_q;
   logic [2:0]    owner_oh;
   logic          others_pending;
   logic [1:0]    pick;

   logic [NUM_REQ-1:0]                 lane_rd_vld;
   logic [NUM_REQ-1:0]                 lane_wr_en;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] lane_rd_addr;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] lane_wr_addr;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_wr_data;

   // first requesting index searching cyclically from last+1; scanning
   // backwards lets the nearest candidate overwrite the farther ones
   function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
      logic [1:0] res;
      int         idx;
      res = 2'd0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = (int'(last) + 1 + i) % NUM_REQ;
         if (req[idx]) res = 2'(idx);
      end
      return res;
   endfunction

   assign pick           = rr_pick(req_i, last_owner);
   assign owner_oh       = 3'(3'b001 << owner);
   assign others_pending = |(req_i & ~owner_oh);

   // state and datapath registers
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state      <= IDLE;
         owner      <= 2'd0;
         last_owner <= 2'd2;
         cnt        <= '0;
         gnt_q      <= 3'b000;
         rd_valid_q <= 3'b000;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         cnt        <= cnt_nxt;
         gnt_q      <= gnt_nxt;
         rd_valid_q <= lane_rd_vld;
      end
   end

   // next-state: burst counting, fair rotation and handover
   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      cnt_nxt        = cnt;
      case (state)
         IDLE: begin
            if (|req_i) begin
               state_nxt = GRANT;
               owner_nxt = pick;
               cnt_nxt   = '0;
            end
         end
         GRANT: begin
            if (!req_i[owner]) begin
               last_owner_nxt = owner;
               state_nxt      = others_pending ? HANDOVER : IDLE;
            end else if (cnt == CNT_LAST) begin
               // burst used up: yield only if someone is actually waiting
               if (others_pending) begin
                  last_owner_nxt = owner;
                  state_nxt      = HANDOVER;
               end else begin
                  cnt_nxt = '0;
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         HANDOVER: begin
            if (|req_i) begin
               state_nxt = GRANT;
               owner_nxt = pick;
               cnt_nxt   = '0;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // outputs: grant follows the state being entered, so gnt_o is a flop
   always_comb begin
      gnt_nxt = (state_nxt == GRANT) ? 3'(3'b001 << owner_nxt) : 3'b000;
      busy_o  = (state != IDLE);
   end

   // RAM port lanes; reset forces the grant off so the port is quiet in reset
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
      ram_port_arbiter_lane #(
         .ADDR_WIDTH(ADDR_WIDTH),
         .DATA_WIDTH(DATA_WIDTH)
      ) u_lane (
         .gnt        (gnt_q[k] & reset_ni),
         .rd_en      (rd_en_i[k]),
         .wr_en      (wr_en_i[k]),
         .rd_addr    (rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]),
         .wr_addr    (wr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]),
         .wr_data    (wr_data_i[k*DATA_WIDTH +: DATA_WIDTH]),
         .rd_vld_nxt (lane_rd_vld[k]),
         .wr_en_m    (lane_wr_en[k]),
         .rd_addr_m  (lane_rd_addr[k]),
         .wr_addr_m  (lane_wr_addr[k]),
         .wr_data_m  (lane_wr_data[k])
      );
   end

   // OR-combine the lanes; at most one is ever non-zero
   always_comb begin
      ram_rd_address_o = '0;
      ram_wr_address_o = '0;
      ram_wr_data_o    = '0;
      ram_wr_en_o      = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         ram_rd_address_o = ram_rd_address_o | lane_rd_addr[k];
         ram_wr_address_o = ram_wr_address_o | lane_wr_addr[k];
         ram_wr_data_o    = ram_wr_data_o    | lane_wr_data[k];
         ram_wr_en_o      = ram_wr_en_o      | lane_wr_en[k];
      end
   end

   assign gnt_o      = gnt_q;
   assign rd_valid_o = rd_valid_q;
   assign rd_data_o  = ram_rd_data_i;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: rotation, long single-owner bursts,
// grant masking of the RAM port, read latency and mid-burst reset.
module tb_ram_port_arbiter;

   localparam int AW = 19;
   localparam int DW = 2;
   localparam int MB = 16;

   logic            clk_i = 1'b0;
   logic            reset_ni;
   logic [2:0]      req_i, rd_en_i, wr_en_i;
   logic [3*AW-1:0] rd_addr_i, wr_addr_i;
   logic [3*DW-1:0] wr_data_i;
   logic [DW-1:0]   ram_rd_data_i = '0;
   logic [2:0]      gnt_o, rd_valid_o;
   logic [DW-1:0]   rd_data_o;
   logic [AW-1:0]   ram_rd_address_o, ram_wr_address_o;
   logic [DW-1:0]   ram_wr_data_o;
   logic            ram_wr_en_o, busy_o;

   int checks = 0;
   int errors = 0;

   ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk_i            (clk_i),
      .reset_ni         (reset_ni),
      .req_i            (req_i),
      .rd_en_i          (rd_en_i),
      .wr_en_i          (wr_en_i),
      .rd_addr_i        (rd_addr_i),
      .wr_addr_i        (wr_addr_i),
      .wr_data_i        (wr_data_i),
      .ram_rd_data_i    (ram_rd_data_i),
      .gnt_o            (gnt_o),
      .rd_valid_o       (rd_valid_o),
      .rd_data_o        (rd_data_o),
      .ram_rd_address_o (ram_rd_address_o),
      .ram_wr_address_o (ram_wr_address_o),
      .ram_wr_data_o    (ram_wr_data_o),
      .ram_wr_en_o      (ram_wr_en_o),
      .busy_o           (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // RAM stand-in: registered read, contents = low address bits xor 2'b10
   always @(posedge clk_i) ram_rd_data_i <= ram_rd_address_o[1:0] ^ 2'b10;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // checks gnt each cycle, leaves the bench n edges later
   task automatic run_burst(input string tag, input logic [2:0] exp, input int n);
      for (int i = 0; i < n; i++) begin
         chk(tag, 32'(gnt_o), 32'(exp));
         tick();
      end
   endtask

   initial begin
      reset_ni  = 1'b0;
      req_i     = 3'b000;
      rd_en_i   = 3'b000;
      wr_en_i   = 3'b111;
      rd_addr_i = {3{19'h1ABCD}};
      wr_addr_i = {3{19'h05555}};
      wr_data_i = {3{2'b11}};
      tick();
      tick();
      // reset state and quiet RAM port despite live strobes
      chk("rst_gnt",   32'(gnt_o), 32'h0);
      chk("rst_busy",  32'(busy_o), 32'h0);
      chk("rst_rdv",   32'(rd_valid_o), 32'h0);
      chk("rst_wen",   32'(ram_wr_en_o), 32'h0);
      chk("rst_raddr", 32'(ram_rd_address_o), 32'h0);
      chk("rst_waddr", 32'(ram_wr_address_o), 32'h0);
      wr_en_i = 3'b000;

      // all three requesting: 0 first, then rotate 1, 2, back to 0
      reset_ni = 1'b1;
      req_i    = 3'b111;
      tick();
      run_burst("rr_g0", 3'b001, MB);
      chk("rr_ho0_gnt",  32'(gnt_o), 32'h0);
      chk("rr_ho0_busy", 32'(busy_o), 32'h1);
      tick();
      run_burst("rr_g1", 3'b010, MB);
      chk("rr_ho1_gnt", 32'(gnt_o), 32'h0);
      tick();
      run_burst("rr_g2", 3'b100, MB);
      chk("rr_ho2_gnt", 32'(gnt_o), 32'h0);
      tick();
      chk("rr_wrap", 32'(gnt_o), 32'h1);
      req_i = 3'b000;
      tick();
      chk("idle_gnt",  32'(gnt_o), 32'h0);
      chk("idle_busy", 32'(busy_o), 32'h0);

      // lone requester 1 keeps the RAM past MAX_BURST without a gap
      req_i = 3'b010;
      tick();
      for (int i = 0; i < 40; i++) begin
         chk("solo_gnt",  32'(gnt_o), 32'h2);
         chk("solo_busy", 32'(busy_o), 32'h1);
         tick();
      end
      req_i = 3'b000;
      tick();
      chk("solo_end", 32'(busy_o), 32'h0);

      // owner 2 write while requester 0 strobes too
      req_i = 3'b100;
      tick();
      chk("w_gnt", 32'(gnt_o), 32'h4);
      wr_addr_i = {19'h12345, 19'h00000, 19'h7FFFF};
      wr_data_i = {2'b11, 2'b00, 2'b01};
      rd_addr_i = {19'h00ABC, 19'h00000, 19'h00777};
      wr_en_i   = 3'b101;
      rd_en_i   = 3'b101;
      #1;
      chk("w_wen",   32'(ram_wr_en_o), 32'h1);
      chk("w_waddr", 32'(ram_wr_address_o), 32'h12345);
      chk("w_wdata", 32'(ram_wr_data_o), 32'h3);
      chk("w_raddr", 32'(ram_rd_address_o), 32'h00ABC);
      tick();
      chk("w_rdv", 32'(rd_valid_o), 32'h4);
      wr_en_i = 3'b001;
      rd_en_i = 3'b000;
      #1;
      chk("w_ign_wen", 32'(ram_wr_en_o), 32'h0);
      req_i   = 3'b000;
      wr_en_i = 3'b000;
      tick();
      chk("w_end_gnt", 32'(gnt_o), 32'h0);
      chk("w_end_rdv", 32'(rd_valid_o), 32'h0);

      // owner 0 reads addr 5 on its final grant cycle
      req_i = 3'b001;
      tick();
      chk("r_gnt", 32'(gnt_o), 32'h1);
      rd_addr_i = '0;
      rd_addr_i[AW-1:0] = 19'd5;
      rd_en_i = 3'b001;
      req_i   = 3'b000;
      #1;
      chk("r_addr", 32'(ram_rd_address_o), 32'h5);
      tick();
      rd_en_i = 3'b000;
      chk("r_rdv",  32'(rd_valid_o), 32'h1);
      chk("r_data", 32'(rd_data_o), 32'h3);
      chk("r_gnt0", 32'(gnt_o), 32'h0);
      chk("r_busy", 32'(busy_o), 32'h0);
      tick();
      chk("r_rdv_off", 32'(rd_valid_o), 32'h0);

      // reset pulsed mid-burst with a write and a read in flight
      req_i = 3'b001;
      tick();
      chk("mr_gnt", 32'(gnt_o), 32'h1);
      wr_addr_i = '0;
      wr_addr_i[AW-1:0] = 19'h00111;
      wr_en_i = 3'b001;
      rd_en_i = 3'b001;
      #1;
      chk("mr_wen_pre", 32'(ram_wr_en_o), 32'h1);
      reset_ni = 1'b0;
      #1;
      chk("mr_wen_rst",   32'(ram_wr_en_o), 32'h0);
      chk("mr_waddr_rst", 32'(ram_wr_address_o), 32'h0);
      tick();
      chk("mr_gnt_post",  32'(gnt_o), 32'h0);
      chk("mr_wen_post",  32'(ram_wr_en_o), 32'h0);
      chk("mr_rdv_post",  32'(rd_valid_o), 32'h0);
      chk("mr_busy_post", 32'(busy_o), 32'h0);
      reset_ni = 1'b1;
      req_i    = 3'b000;
      wr_en_i  = 3'b000;
      rd_en_i  = 3'b000;
      tick();
      chk("mr_idle", 32'(busy_o), 32'h0);

      // owner drops with another pending, which then leaves during HANDOVER
      req_i = 3'b011;
      tick();
      chk("hi_gnt", 32'(gnt_o), 32'h1);
      req_i = 3'b010;
      tick();
      chk("hi_ho_gnt",  32'(gnt_o), 32'h0);
      chk("hi_ho_busy", 32'(busy_o), 32'h1);
      req_i = 3'b000;
      tick();
      chk("hi_idle_gnt",  32'(gnt_o), 32'h0);
      chk("hi_idle_busy", 32'(busy_o), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
